parity_gen: RTL and testbench

- Registered parity generator for a WIDTH-bit data word (default 4).
- Each accepted word produces:
  - a parity bit for the configured parity mode;
  - an odd/even weight flag;
  - a ones count.
- Sits at the edge of a datapath. It appends protection bits to words before storage or transmission, and serves as a reusable checker front-end.
- All outputs are registered. Latency is fixed at one clock.

---
 rtl/parity_pkg.sv | 12 +
 rtl/parity_tree.sv | 41 ++++
 rtl/parity_gen.sv | 72 +++++++
 tb/tb_parity_gen.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/parity_pkg.sv
// Shared constants and width helper for the parity generator slice.
package parity_pkg;

  localparam int PAR_EVEN = 0;
  localparam int PAR_ODD  = 1;

  // Bits needed to hold a population count of 0..w.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/parity_tree.sv
// Combinational XOR-reduction and popcount of a data word, built as a
// balanced binary tree over a power-of-two padded leaf set.
module parity_tree
  import parity_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]            data_in,
  output logic                        parity,
  output logic [cnt_width(WIDTH)-1:0] ones_cnt
);

  localparam int CW     = cnt_width(WIDTH);
  localparam int LEVELS = (WIDTH > 1) ? $clog2(WIDTH) : 0;
  localparam int N      = 1 << LEVELS;

  logic [N-1:0]  data_pad;
  logic [CW-1:0] cnt_node [1:2*N-1];
  logic          par_node [1:2*N-1];

  assign data_pad = N'(data_in);

  // Heap layout: leaves at N..2N-1, node k combines children 2k and 2k+1,
  // root at 1; partial sums never exceed WIDTH so CW bits suffice everywhere.
  always_comb begin
    cnt_node = '{default: '0};
    par_node = '{default: 1'b0};
    for (int unsigned i = 0; i < N; i++) begin
      cnt_node[N+i] = CW'(data_pad[i]);
      par_node[N+i] = data_pad[i];
    end
    for (int unsigned k = N - 1; k >= 1; k--) begin
      cnt_node[k] = cnt_node[2*k] + cnt_node[2*k+1];
      par_node[k] = par_node[2*k] ^ par_node[2*k+1];
    end
  end

  assign ones_cnt = cnt_node[1];
  assign parity   = par_node[1];

endmodule

// File: rtl/parity_gen.sv
// Registered parity generator: parity bit, weight flag and ones count of each
// accepted word, one cycle after capture.
module parity_gen
  import parity_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int ODD_PARITY = PAR_EVEN
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [WIDTH-1:0]            data_in,
  output logic                        data_out,
  output logic                        odd_even,
  output logic [cnt_width(WIDTH)-1:0] ones_cnt,
  output logic                        out_valid
);

  localparam int   CW  = cnt_width(WIDTH);
  localparam logic INV = (ODD_PARITY == PAR_ODD) ? 1'b1 : 1'b0;

  logic          tree_par;
  logic [CW-1:0] tree_cnt;

  logic          data_out_q,  data_out_d;
  logic          odd_even_q,  odd_even_d;
  logic [CW-1:0] ones_cnt_q,  ones_cnt_d;
  logic          out_valid_q, out_valid_d;

  parity_tree #(
    .WIDTH (WIDTH)
  ) u_tree (
    .data_in  (data_in),
    .parity   (tree_par),
    .ones_cnt (tree_cnt)
  );

  // Tree results are only selected when in_valid is high, so an undriven
  // data_in on idle cycles never reaches the registers.
  always_comb begin
    data_out_d  = data_out_q;
    odd_even_d  = odd_even_q;
    ones_cnt_d  = ones_cnt_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      odd_even_d  = tree_par;
      data_out_d  = tree_par ^ INV;
      ones_cnt_d  = tree_cnt;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_q  <= 1'b0;
      odd_even_q  <= 1'b0;
      ones_cnt_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      data_out_q  <= data_out_d;
      odd_even_q  <= odd_even_d;
      ones_cnt_q  <= ones_cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign data_out  = data_out_q;
  assign odd_even  = odd_even_q;
  assign ones_cnt  = ones_cnt_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_parity_gen.sv
// Scoreboard bench for parity_gen: even/odd 4-bit and even 8-bit instances
// driven in lockstep, outputs checked on the falling edge.
module tb_parity_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] data4;
  logic [7:0] data8;

  logic       ev_dout, ev_oe, ev_ov;
  logic [2:0] ev_cnt;
  logic       od_dout, od_oe, od_ov;
  logic [2:0] od_cnt;
  logic       wd_dout, wd_oe, wd_ov;
  logic [3:0] wd_cnt;

  typedef struct packed {
    logic       p4;
    logic [2:0] c4;
    logic       od4;
    logic       p8;
    logic [3:0] c8;
  } exp_t;

  exp_t sb[$];
  exp_t hold;
  logic exp_valid;
  logic mon_en = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  parity_gen #(.WIDTH(4), .ODD_PARITY(0)) u_even (
    .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data4),
    .data_out(ev_dout), .odd_even(ev_oe), .ones_cnt(ev_cnt), .out_valid(ev_ov)
  );

  parity_gen #(.WIDTH(4), .ODD_PARITY(1)) u_odd (
    .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data4),
    .data_out(od_dout), .odd_even(od_oe), .ones_cnt(od_cnt), .out_valid(od_ov)
  );

  parity_gen #(.WIDTH(8), .ODD_PARITY(0)) u_wide (
    .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data8),
    .data_out(wd_dout), .odd_even(wd_oe), .ones_cnt(wd_cnt), .out_valid(wd_ov)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int popcnt(input logic [7:0] v);
    int n = 0;
    for (int i = 0; i < 8; i++) if (v[i]) n++;
    return n;
  endfunction

  task automatic step(input logic r, input logic v, input logic [3:0] d4, input logic [7:0] d8);
    exp_t e;
    rst = r; in_valid = v; data4 = d4; data8 = d8;
    @(posedge clk);
    if (r) begin
      hold = '0;
      exp_valid = 1'b0;
    end else if (v) begin
      e.p4  = ^d4;
      e.c4  = 3'(popcnt({4'h0, d4}));
      e.od4 = ~(^d4);
      e.p8  = ^d8;
      e.c8  = 4'(popcnt(d8));
      sb.push_back(e);
      hold = e;
      exp_valid = 1'b1;
    end else begin
      exp_valid = 1'b0;
    end
    mon_en = 1'b1;
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      check("valid_even", ev_ov, exp_valid);
      check("valid_odd",  od_ov, exp_valid);
      check("valid_wide", wd_ov, exp_valid);
      e = hold;
      if (ev_ov) begin
        check("sb_avail", 64'(sb.size() != 0), 1);
        if (sb.size() != 0) e = sb.pop_front();
      end
      check("even_dout", ev_dout, e.p4);
      check("even_oe",   ev_oe,   e.p4);
      check("even_cnt",  ev_cnt,  e.c4);
      check("odd_dout",  od_dout, e.od4);
      check("odd_oe",    od_oe,   e.p4);
      check("odd_cnt",   od_cnt,  e.c4);
      check("wide_dout", wd_dout, e.p8);
      check("wide_oe",   wd_oe,   e.p8);
      check("wide_cnt",  wd_cnt,  e.c8);
    end
  end

  initial begin
    hold = '0;
    exp_valid = 1'b0;
    // Reset dominates an asserted in_valid
    step(1, 1, 4'hF, 8'hFF);
    step(1, 1, 4'hF, 8'hFF);
    step(0, 0, 4'hF, 8'hFF);
    step(0, 0, 4'h3, 8'h0F);
    // Back-to-back exhaustive sweep of the 4-bit word
    for (int i = 0; i < 16; i++) step(0, 1, 4'(i), 8'(i * 37));
    // Wide boundary words
    step(0, 1, 4'b0111, 8'hFF);
    step(0, 1, 4'b1001, 8'h80);
    step(0, 1, 4'b0000, 8'h00);
    // Hold after a single word
    step(0, 1, 4'b0001, 8'h80);
    for (int i = 0; i < 3; i++) step(0, 0, 4'b1110, 8'h7F);
    // Reset collision: the second word must never be reported
    step(0, 1, 4'b0101, 8'hFF);
    step(1, 1, 4'b0100, 8'h01);
    step(0, 0, 4'b0100, 8'h01);
    step(0, 1, 4'b1011, 8'hFF);
    step(0, 0, 4'b0000, 8'h00);
    // Random mix of valid, idle and reset cycles
    for (int i = 0; i < 40; i++)
      step(($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)),
           4'($urandom), 8'($urandom));
    step(0, 0, 4'h0, 8'h00);
    step(0, 0, 4'h0, 8'h00);
    check("sb_drained", 64'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
